// File: rtl/br_resolve_if.sv
// br_resolve_if: scheduler, branch-unit and ROB-head signals seen by br_resolve_q
interface br_resolve_if #(parameter int TAG_W = 4);
    logic             alloc;
    logic [TAG_W-1:0] alloc_tag;
    logic             alloc_pred_taken;
    logic             resolve_valid;
    logic [TAG_W-1:0] resolve_tag;
    logic             resolve_taken;
    logic [31:0]      resolve_target;
    logic [TAG_W-1:0] rob_head_tag;
    logic             rob_head_valid;
    logic             commit_jump;
    logic             flush;
    logic [31:0]      redirect_pc;
    logic             q_full;
    logic             q_empty;
    modport master(
        output alloc, alloc_tag, alloc_pred_taken, resolve_valid, resolve_tag, resolve_taken,
               resolve_target, rob_head_tag, rob_head_valid,
        input  commit_jump, flush, redirect_pc, q_full, q_empty
    );
    modport slave(
        input  alloc, alloc_tag, alloc_pred_taken, resolve_valid, resolve_tag, resolve_taken,
               resolve_target, rob_head_tag, rob_head_valid,
        output commit_jump, flush, redirect_pc, q_full, q_empty
    );
endinterface

// File: rtl/br_resolve_q.sv
// br_resolve_q: in-order branch retire queue with out-of-order resolution; BR_RESOLVE_STATS_EN adds commit/mispredict counters
module br_resolve_q #(
    parameter int Q_IDX = 3,
    parameter int TAG_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    br_resolve_if.slave bus
`ifdef BR_RESOLVE_STATS_EN
    ,
    output logic [31:0] br_commit_cnt,
    output logic [31:0] br_mispredict_cnt
`endif
);
    localparam int N = 1 << Q_IDX;
    localparam logic [Q_IDX:0] ONE = 1;
    localparam logic [Q_IDX:0] FULL = {1'b1, {Q_IDX{1'b0}}};
    typedef enum logic {RUN, FLUSH} state_t;
    state_t state, state_nx;
    logic [Q_IDX:0] head, tail, count;
    logic [Q_IDX-1:0] hidx, tidx;
    logic [N-1:0] valid, resolved, mispred, preds, hit;
    logic [TAG_W-1:0] tags [N];
    logic [31:0] targets [N];
    logic run, retire, mis_retire, do_alloc;
    assign run = state == RUN;
    assign hidx = head[Q_IDX-1:0];
    assign tidx = tail[Q_IDX-1:0];
    assign count = tail - head;
    assign bus.q_full = count == FULL;
    assign bus.q_empty = head == tail;
    // retire sees only registered resolution state, so resolve->commit is never same-cycle
    assign retire = run && valid[hidx] && resolved[hidx] && bus.rob_head_valid
                    && bus.rob_head_tag == tags[hidx];
    assign mis_retire = retire && mispred[hidx];
    assign do_alloc = run && bus.alloc && !mis_retire && (!bus.q_full || retire);
    for (genvar i = 0; i < N; i++) begin : g_cam
        assign hit[i] = run && bus.resolve_valid && valid[i] && !resolved[i]
                        && tags[i] == bus.resolve_tag;
    end
    always_ff @(posedge clk) begin
        state <= rst ? RUN : state_nx;
    end
    always_comb begin
        state_nx = (run && mis_retire) ? FLUSH : RUN;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            valid <= '0;
            resolved <= '0;
            mispred <= '0;
            bus.commit_jump <= 1'b0;
            bus.flush <= 1'b0;
            bus.redirect_pc <= '0;
        end else begin
            bus.commit_jump <= retire;
            bus.flush <= mis_retire;
            bus.redirect_pc <= mis_retire ? targets[hidx] : '0;
            if (mis_retire) begin
                head <= '0;
                tail <= '0;
                valid <= '0;
                resolved <= '0;
                mispred <= '0;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (hit[i]) begin
                        resolved[i] <= 1'b1;
                        mispred[i] <= bus.resolve_taken != preds[i];
                        targets[i] <= bus.resolve_target;
                    end
                end
                if (retire) begin
                    valid[hidx] <= 1'b0;
                    head <= head + ONE;
                end
                // on a full queue with retire, tidx == hidx: this write must win over the clear above
                if (do_alloc) begin
                    valid[tidx] <= 1'b1;
                    resolved[tidx] <= 1'b0;
                    mispred[tidx] <= 1'b0;
                    preds[tidx] <= bus.alloc_pred_taken;
                    tags[tidx] <= bus.alloc_tag;
                    tail <= tail + ONE;
                end
            end
        end
    end
`ifdef BR_RESOLVE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            br_commit_cnt <= '0;
            br_mispredict_cnt <= '0;
        end else begin
            if (retire && br_commit_cnt != '1) br_commit_cnt <= br_commit_cnt + 32'd1;
            if (mis_retire && br_mispredict_cnt != '1) br_mispredict_cnt <= br_mispredict_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_br_resolve_q.sv
// tb_br_resolve_q: directed scenarios plus randomized traffic against a queue-based reference model
module tb_br_resolve_q;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    br_resolve_if #(.TAG_W(4)) bus();
`ifdef BR_RESOLVE_STATS_EN
    logic [31:0] commit_cnt, mispredict_cnt;
`endif
    br_resolve_q #(.Q_IDX(3), .TAG_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef BR_RESOLVE_STATS_EN
        ,
        .br_commit_cnt(commit_cnt),
        .br_mispredict_cnt(mispredict_cnt)
`endif
    );
    int checks = 0;
    int failures = 0;
    wire [3:0] st = {bus.commit_jump, bus.flush, bus.q_full, bus.q_empty};

    // reference model: program-order list of live branches
    typedef struct {
        logic [3:0]  tag;
        logic        pred;
        logic        res;
        logic        mis;
        logic [31:0] tgt;
    } ent_t;
    ent_t mq[$];
    logic m_in_flush = 1'b0;
    logic e_cj = 1'b0, e_fl = 1'b0;
    logic [31:0] e_rpc = '0;
    logic [3:0] next_tag = '0;

    task automatic model_step();
        logic ret, mis, was_flush;
        if (rst) begin
            mq.delete();
            m_in_flush = 1'b0;
            e_cj = 1'b0;
            e_fl = 1'b0;
            e_rpc = '0;
            return;
        end
        was_flush = m_in_flush;
        ret = !was_flush && mq.size() > 0 && mq[0].res && bus.rob_head_valid
              && bus.rob_head_tag == mq[0].tag;
        mis = ret && mq[0].mis;
        e_cj = ret;
        e_fl = mis;
        e_rpc = mis ? mq[0].tgt : 32'h0;
        m_in_flush = mis;
        if (mis) begin
            mq.delete();
            return;
        end
        if (was_flush) return;
        if (bus.resolve_valid)
            foreach (mq[i])
                if (!mq[i].res && mq[i].tag == bus.resolve_tag) begin
                    mq[i].res = 1'b1;
                    mq[i].mis = bus.resolve_taken != mq[i].pred;
                    mq[i].tgt = bus.resolve_target;
                end
        if (ret) void'(mq.pop_front());
        if (bus.alloc && mq.size() < 8) begin
            mq.push_back('{tag: bus.alloc_tag, pred: bus.alloc_pred_taken, res: 1'b0, mis: 1'b0, tgt: 32'h0});
            next_tag = next_tag + 4'd1;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.alloc = 1'b0;
        bus.alloc_tag = '0;
        bus.alloc_pred_taken = 1'b0;
        bus.resolve_valid = 1'b0;
        bus.resolve_tag = '0;
        bus.resolve_taken = 1'b0;
        bus.resolve_target = '0;
        bus.rob_head_tag = '0;
        bus.rob_head_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic alloc_one(input logic [3:0] t, input logic p);
        bus.alloc = 1'b1;
        bus.alloc_tag = t;
        bus.alloc_pred_taken = p;
    endtask

    task automatic resolve_one(input logic [3:0] t, input logic tk, input logic [31:0] tg);
        bus.resolve_valid = 1'b1;
        bus.resolve_tag = t;
        bus.resolve_taken = tk;
        bus.resolve_target = tg;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (st !== 4'b0001 || bus.redirect_pc !== 32'h0) begin
            failures++;
            $display("FAIL reset_state got st=%b rpc=%h exp st=0001 rpc=0", st, bus.redirect_pc);
        end
        alloc_one(4'd1, 1'b0);
        cyc();
        bus.alloc = 1'b0;
        resolve_one(4'd1, 1'b0, 32'h104);
        cyc();
        bus.resolve_valid = 1'b0;
        bus.rob_head_tag = 4'd1;
        bus.rob_head_valid = 1'b1;
        rst = 1'b1;
        cyc();
        checks++;
        if (st !== 4'b0001) begin
            failures++;
            $display("FAIL reset_mid_op got st=%b exp 0001", st);
        end
        rst = 1'b0;
        cyc();
        checks++;
        if (st !== 4'b0001) begin
            failures++;
            $display("FAIL reset_discard got st=%b exp 0001", st);
        end
        idle();
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            alloc_one(i[3:0], 1'b0);
            cyc();
            if (i == 6) begin
                checks++;
                if (st !== 4'b0000) begin
                    failures++;
                    $display("FAIL fill_7 got st=%b exp 0000", st);
                end
            end
        end
        checks++;
        if (st !== 4'b0010) begin
            failures++;
            $display("FAIL fill_full got st=%b exp 0010", st);
        end
        alloc_one(4'd8, 1'b0);
        cyc();
        checks++;
        if (st !== 4'b0010) begin
            failures++;
            $display("FAIL fill_drop got st=%b exp 0010", st);
        end
        bus.alloc = 1'b0;
        for (int i = 0; i < 8; i++) begin
            resolve_one(i[3:0], 1'b0, 32'h100 + 32'(i));
            cyc();
        end
        bus.resolve_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.rob_head_tag = i[3:0];
            bus.rob_head_valid = 1'b1;
            bus.alloc = i == 0;
            bus.alloc_tag = 4'd9;
            cyc();
            checks++;
            if (st !== {1'b1, 1'b0, i == 0, 1'b0}) begin
                failures++;
                $display("FAIL fill_retire%0d got st=%b exp %b", i, st, {1'b1, 1'b0, i == 0, 1'b0});
            end
        end
        bus.alloc = 1'b0;
        resolve_one(4'd9, 1'b0, 32'h900);
        bus.rob_head_tag = 4'd9;
        cyc();
        checks++;
        if (st !== 4'b0000) begin
            failures++;
            $display("FAIL fill_tag9_wait got st=%b exp 0000", st);
        end
        bus.resolve_valid = 1'b0;
        cyc();
        checks++;
        if (st !== 4'b1001) begin
            failures++;
            $display("FAIL fill_tag9_retire got st=%b exp 1001", st);
        end
        idle();
    endtask

    task automatic test_correct();
        do_reset();
        alloc_one(4'd3, 1'b0);
        cyc();
        bus.alloc = 1'b0;
        resolve_one(4'd3, 1'b0, 32'h104);
        bus.rob_head_tag = 4'd3;
        bus.rob_head_valid = 1'b1;
        cyc();
        checks++;
        if (st !== 4'b0000) begin
            failures++;
            $display("FAIL correct_early got st=%b exp 0000", st);
        end
        bus.resolve_valid = 1'b0;
        cyc();
        checks++;
        if (st !== 4'b1001 || bus.redirect_pc !== 32'h0) begin
            failures++;
            $display("FAIL correct_commit got st=%b rpc=%h exp st=1001 rpc=0", st, bus.redirect_pc);
        end
        cyc();
        checks++;
        if (st !== 4'b0001) begin
            failures++;
            $display("FAIL correct_pulse_end got st=%b exp 0001", st);
        end
        idle();
    endtask

    task automatic test_out_of_order();
        do_reset();
        alloc_one(4'd1, 1'b1);
        cyc();
        alloc_one(4'd2, 1'b1);
        cyc();
        bus.alloc = 1'b0;
        resolve_one(4'd2, 1'b1, 32'h200);
        bus.rob_head_tag = 4'd1;
        bus.rob_head_valid = 1'b1;
        cyc();
        checks++;
        if (st !== 4'b0000) begin
            failures++;
            $display("FAIL ooo_young_first got st=%b exp 0000", st);
        end
        resolve_one(4'd1, 1'b1, 32'h100);
        cyc();
        checks++;
        if (st !== 4'b0000) begin
            failures++;
            $display("FAIL ooo_no_bypass got st=%b exp 0000", st);
        end
        bus.resolve_valid = 1'b0;
        cyc();
        checks++;
        if (st !== 4'b1000) begin
            failures++;
            $display("FAIL ooo_retire1 got st=%b exp 1000", st);
        end
        cyc();
        checks++;
        if (st !== 4'b0000) begin
            failures++;
            $display("FAIL ooo_hold_tag2 got st=%b exp 0000", st);
        end
        bus.rob_head_tag = 4'd2;
        cyc();
        checks++;
        if (st !== 4'b1001) begin
            failures++;
            $display("FAIL ooo_retire2 got st=%b exp 1001", st);
        end
        idle();
    endtask

    task automatic test_mispredict();
        do_reset();
        for (int i = 5; i < 8; i++) begin
            alloc_one(i[3:0], 1'b1);
            cyc();
        end
        bus.alloc = 1'b0;
        resolve_one(4'd5, 1'b0, 32'h2000_0040);
        bus.rob_head_tag = 4'd5;
        bus.rob_head_valid = 1'b1;
        cyc();
        checks++;
        if (st !== 4'b0000) begin
            failures++;
            $display("FAIL misp_wait got st=%b exp 0000", st);
        end
        bus.resolve_valid = 1'b0;
        alloc_one(4'd11, 1'b0);
        cyc();
        checks++;
        if (st !== 4'b1101 || bus.redirect_pc !== 32'h2000_0040) begin
            failures++;
            $display("FAIL misp_flush got st=%b rpc=%h exp st=1101 rpc=20000040", st, bus.redirect_pc);
        end
        alloc_one(4'd12, 1'b0);
        resolve_one(4'd6, 1'b1, 32'h600);
        bus.rob_head_tag = 4'd6;
        cyc();
        checks++;
        if (st !== 4'b0001 || bus.redirect_pc !== 32'h0) begin
            failures++;
            $display("FAIL misp_flush_cycle got st=%b rpc=%h exp st=0001 rpc=0", st, bus.redirect_pc);
        end
        bus.resolve_valid = 1'b0;
        alloc_one(4'd13, 1'b0);
        bus.rob_head_tag = 4'd13;
        cyc();
        checks++;
        if (st !== 4'b0000) begin
            failures++;
            $display("FAIL misp_alloc_after got st=%b exp 0000", st);
        end
        bus.alloc = 1'b0;
        resolve_one(4'd13, 1'b0, 32'h44);
        cyc();
        bus.resolve_valid = 1'b0;
        cyc();
        checks++;
        if (st !== 4'b1001) begin
            failures++;
            $display("FAIL misp_recover got st=%b exp 1001", st);
        end
        idle();
    endtask

    task automatic test_wrap_stats();
        logic m;
        logic [31:0] tg;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            m = i >= 16 && i <= 18;
            tg = 32'h1000 + 32'(i * 4);
            alloc_one(i[3:0], 1'b1);
            cyc();
            bus.alloc = 1'b0;
            resolve_one(i[3:0], !m, tg);
            bus.rob_head_tag = i[3:0];
            bus.rob_head_valid = 1'b1;
            cyc();
            checks++;
            if (st !== 4'b0000) begin
                failures++;
                $display("FAIL wrap_pending%0d got st=%b exp 0000", i, st);
            end
            bus.resolve_valid = 1'b0;
            cyc();
            checks++;
            if (st !== {1'b1, m, 2'b01} || bus.redirect_pc !== (m ? tg : 32'h0)) begin
                failures++;
                $display("FAIL wrap_retire%0d got st=%b rpc=%h exp st=%b rpc=%h",
                         i, st, bus.redirect_pc, {1'b1, m, 2'b01}, m ? tg : 32'h0);
            end
            bus.rob_head_valid = 1'b0;
            if (m) cyc();
        end
`ifdef BR_RESOLVE_STATS_EN
        checks++;
        if (commit_cnt !== 32'd20 || mispredict_cnt !== 32'd3) begin
            failures++;
            $display("FAIL stats got commit=%0d misp=%0d exp commit=20 misp=3", commit_cnt, mispredict_cnt);
        end
`endif
        idle();
    endtask

    task automatic test_random();
        int k;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            rst = $urandom_range(0, 299) == 0;
            bus.alloc = mq.size() < 8 ? $urandom_range(0, 1) == 1 : $urandom_range(0, 7) == 0;
            bus.alloc_tag = next_tag;
            bus.alloc_pred_taken = $urandom_range(0, 1) == 1;
            bus.resolve_valid = 1'b0;
            if (mq.size() > 0 && $urandom_range(0, 1) == 1) begin
                k = $urandom_range(0, mq.size() - 1);
                resolve_one(mq[k].tag, mq[k].pred ^ ($urandom_range(0, 9) == 0), $urandom());
            end else if ($urandom_range(0, 9) == 0) begin
                resolve_one(4'($urandom()), $urandom_range(0, 1) == 1, $urandom());
            end
            bus.rob_head_valid = $urandom_range(0, 4) != 0;
            bus.rob_head_tag = (mq.size() > 0 && $urandom_range(0, 3) != 0) ? mq[0].tag : 4'($urandom());
            cyc();
            checks++;
            if ({st, bus.redirect_pc} !== {e_cj, e_fl, mq.size() == 8, mq.size() == 0, e_rpc}) begin
                failures++;
                $display("FAIL random_c%0d got st=%b rpc=%h exp st=%b rpc=%h", c, st, bus.redirect_pc,
                         {e_cj, e_fl, mq.size() == 8, mq.size() == 0}, e_rpc);
            end
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_fill();
        test_correct();
        test_out_of_order();
        test_mispredict();
        test_wrap_stats();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/br_resolve_q.md
Name: br_resolve_q

Overview:
- Commit-side counterpart of the branch/store issue-count queue.
- The scheduler allocates one entry per issued branch/jump, in program order.
- The branch unit writes resolutions out of order, by ROB tag.
- When the oldest entry is resolved and is at the ROB head, the block retires it: it pulses commit_jump, and on a mispredict it also pulses flush with a redirect PC.
- It is the producer of the commit_jump/flush pair that the issue-side queue consumes.

Parameters:
- Q_IDX, 3: log2 of entry count (8 entries).
- TAG_W, 4: ROB tag width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- alloc  in  1  scheduler issues a branch; allocate the tail entry.
- alloc_tag  in  TAG_W  ROB tag of the issued branch.
- alloc_pred_taken  in  1  predicted direction.
- resolve_valid  in  1  branch unit result valid.
- resolve_tag  in  TAG_W  ROB tag of the result.
- resolve_taken  in  1  actual direction.
- resolve_target  in  32  correct next PC (target if taken, PC+4 otherwise).
- rob_head_tag  in  TAG_W  tag at the ROB head.
- rob_head_valid  in  1  ROB head is occupied.
- commit_jump  out  1  one-cycle pulse: head branch retired.
- flush  out  1  one-cycle pulse: mispredict, squash younger work.
- redirect_pc  out  32  valid while flush=1.
- q_full  out  1  all 2^Q_IDX entries occupied.
- q_empty  out  1  no entries occupied.

Behaviour:
- **Storage:** circular queue with head/tail pointers of Q_IDX+1 bits (wrap bit).
  - Each entry holds: valid, tag, pred_taken, resolved, mispredict, target.
  - count = tail - head (modulo).
  - q_full = (count == 2^Q_IDX); q_empty = (count == 0). Both are combinational from registered pointers.
- **Reset (sync, rst=1 at posedge):**
  - head = tail = 0; all valid, resolved and mispredict bits = 0.
  - commit_jump = 0, flush = 0, redirect_pc = 0; state = RUN.
  - q_empty = 1, q_full = 0.
  - Reset asserted mid-operation discards all entries; no commit_jump or flush is generated for them.
- **Allocate:**
  - alloc=1 and !q_full in RUN: write the tail entry (valid=1, resolved=0), tail++.
  - alloc while q_full is dropped. This is a protocol error; the scheduler must stall on q_full.
- **Resolve:**
  - resolve_valid=1: CAM search of valid, unresolved entries for tag == resolve_tag.
  - On a match: set resolved=1, mispredict = (resolve_taken != pred_taken), target = resolve_target.
  - No match (e.g. the entry was squashed) is ignored.
  - At most one match is guaranteed by unique ROB tags.
- **Retire:** condition = head entry valid & resolved & rob_head_valid & (rob_head_tag == head tag).
  - Latency: the condition is sampled at edge N; commit_jump=1 during cycle N+1 (registered); head++ at edge N.
  - Mispredict: flush=1 and redirect_pc=target in the same cycle as commit_jump. All entries are cleared and head = tail = 0 at edge N. State goes to FLUSH.
  - At most one retire per cycle.
- **State machine:**
  - RUN → FLUSH: on a mispredict retire.
  - FLUSH → RUN: unconditionally after one cycle.
  - In FLUSH, alloc and resolve_valid are ignored, because the scheduler and branch unit are themselves flushing that cycle.
- **Simultaneous events:**
  - Alloc + non-flush retire in the same cycle: both occur; count unchanged; allowed even when q_full, since retire frees a slot first.
  - Alloc + mispredict retire: the alloc is dropped (it is younger and squashed).
  - Resolve to the head + retire check in the same cycle: the resolution becomes visible to the retire check next cycle. There is no same-cycle bypass, so the minimum resolve→commit_jump latency is 2 cycles.
- **Pointer wrap:** pointers wrap modulo 2^(Q_IDX+1). Full/empty are distinguished by the wrap bit.

Optional Feature:
- Macro: BR_RESOLVE_STATS_EN.
- **Defined:** adds 32-bit output ports br_commit_cnt and br_mispredict_cnt.
  - br_commit_cnt increments on each commit_jump; br_mispredict_cnt increments on each flush.
  - Both saturate at 0xFFFFFFFF and reset to 0 on rst only (not on flush).
- **Undefined:** the ports and counters are absent; all other behaviour is identical.

Test Plan:
- **Reset:** hold rst 2 cycles → q_empty=1, q_full=0, commit_jump=0, flush=0, redirect_pc=0.
- **Fill:** alloc 8 branches with tags 0..7 → q_full=1 after the 8th edge. A 9th alloc with tag 8 is dropped; q_full stays 1.
- **Correct prediction:**
  - Stimulus: alloc tag 3 (pred_taken=0); resolve tag 3, taken=0, target 0x104; rob_head_tag=3.
  - Required: commit_jump pulses exactly 1 cycle, 2 cycles after the resolve; flush=0; q_empty=1.
- **Out-of-order resolve:** alloc tags 1,2; resolve tag 2 first, then tag 1; ROB head steps 1→2 → two commit_jump pulses, tag 1 retired before tag 2.
- **Mispredict:**
  - Stimulus: alloc tags 5,6,7 (all pred_taken=1); resolve tag 5, taken=0, target 0x2000_0040; ROB head=5.
  - Required: flush=1 with redirect_pc=0x2000_0040, coincident with commit_jump. Next cycle q_empty=1. A resolve for tag 6 in the FLUSH cycle is ignored; an alloc 2 cycles later is accepted.
- **Wrap and stats:** 20 alloc/retire pairs with 3 mispredicts → pointers wrap without a false full/empty. With BR_RESOLVE_STATS_EN: br_commit_cnt=20, br_mispredict_cnt=3.
